// File: rtl/jtag_instruction_register_if.sv
// Strobe, serial and decode signals between the TAP controller side and jtag_instruction_register.
// master drives the controller strobes and serial input; slave is the register bank.
interface jtag_instruction_register_if #(
  parameter int unsigned IR_WIDTH = 4
) ();
  logic                Resetn;
  logic                TDI;
  logic                ClockIR;
  logic                ShiftIR;
  logic                UpdateIR;
  logic                ClockDR;
  logic                ShiftDR;
  logic                Select;
  logic                UserTDO;
  logic [IR_WIDTH-1:0] Instr;
  logic                SelBypass;
  logic                SelIdcode;
  logic                SelExtest;
  logic                TDO;

  modport master (
    output Resetn, TDI, ClockIR, ShiftIR, UpdateIR, ClockDR, ShiftDR, Select, UserTDO,
    input  Instr, SelBypass, SelIdcode, SelExtest, TDO
  );

  modport slave (
    input  Resetn, TDI, ClockIR, ShiftIR, UpdateIR, ClockDR, ShiftDR, Select, UserTDO,
    output Instr, SelBypass, SelIdcode, SelExtest, TDO
  );
endinterface

// File: rtl/jtag_instruction_register.sv
// JTAG IR shift/update stages, instruction decode, BYPASS/IDCODE data registers and TDO retiming.
// Define JTAG_IDCODE_EN to build the IDCODE register and make IDCODE the reset instruction.
module jtag_instruction_register #(
  parameter int unsigned         IR_WIDTH      = 4,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = 4'b0001
) (
  input logic                        TCK,
  input logic                        TRST,
  jtag_instruction_register_if.slave jif
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] OP_EXTEST  = '0;
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_RESET   = IDCODE_OPCODE;
`else
  localparam logic [IR_WIDTH-1:0] OP_RESET   = OP_BYPASS;
`endif

  logic                rst_any;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                bypass_q, bypass_d;
  logic                sel_bypass, sel_idcode, sel_extest;
  logic                dr_capture, dr_shift;
  logic                idcode_bit;
  logic                tdo_mux, tdo_q;

  assign rst_any    = TRST | ~jif.Resetn;
  assign dr_capture = jif.ClockDR & ~jif.ShiftDR;
  assign dr_shift   = jif.ClockDR & jif.ShiftDR;
  assign sel_bypass = (instr_q == OP_BYPASS);
  assign sel_extest = (instr_q == OP_EXTEST);

  // An UpdateIR coinciding with ClockIR takes the pre-shift content and drops the shift.
  always_comb begin
    ir_sr_d = ir_sr_q;
    instr_d = instr_q;
    if (jif.UpdateIR) begin
      instr_d = ir_sr_q;
    end else if (jif.ClockIR) begin
      ir_sr_d = jif.ShiftIR ? {jif.TDI, ir_sr_q[IR_WIDTH-1:1]} : IR_CAPTURE;
    end
  end

  always_comb begin
    bypass_d = bypass_q;
    if (sel_bypass | sel_extest) begin
      if (dr_capture) begin
        bypass_d = 1'b0;
      end else if (dr_shift) begin
        bypass_d = jif.TDI;
      end
    end
  end

  always_ff @(posedge TCK) begin
    if (rst_any) begin
      ir_sr_q  <= IR_CAPTURE;
      instr_q  <= OP_RESET;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      instr_q  <= instr_d;
      bypass_q <= bypass_d;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_sr_q, idcode_sr_d;

  assign sel_idcode = (instr_q == IDCODE_OPCODE);
  assign idcode_bit = idcode_sr_q[0];

  always_comb begin
    idcode_sr_d = idcode_sr_q;
    if (sel_idcode) begin
      if (dr_capture) begin
        idcode_sr_d = IDCODE_VALUE;
      end else if (dr_shift) begin
        idcode_sr_d = {jif.TDI, idcode_sr_q[31:1]};
      end
    end
  end

  always_ff @(posedge TCK) begin
    if (rst_any) begin
      idcode_sr_q <= IDCODE_VALUE;
    end else begin
      idcode_sr_q <= idcode_sr_d;
    end
  end
`else
  // Without the IDCODE register its opcode falls through to the user-instruction path.
  logic unused_idcode;
  assign unused_idcode = ^{IDCODE_VALUE, IDCODE_OPCODE};
  assign sel_idcode    = 1'b0;
  assign idcode_bit    = 1'b0;
`endif

  always_comb begin
    if (jif.Select) begin
      tdo_mux = ir_sr_q[0];
    end else if (sel_idcode) begin
      tdo_mux = idcode_bit;
    end else if (sel_bypass | sel_extest) begin
      tdo_mux = bypass_q;
    end else begin
      tdo_mux = jif.UserTDO;
    end
  end

  // Falling-edge retime: TDO is stable across the next rising edge seen by the downstream device.
  always_ff @(negedge TCK) begin
    if (TRST) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= tdo_mux;
    end
  end

  assign jif.Instr     = instr_q;
  assign jif.SelBypass = sel_bypass;
  assign jif.SelIdcode = sel_idcode;
  assign jif.SelExtest = sel_extest;
  assign jif.TDO       = tdo_q;

endmodule

// File: tb/tb_jtag_instruction_register.sv
// Bench for jtag_instruction_register: vector table plus hand-written scans, TDO checked via a queue.
// Expectations follow JTAG_IDCODE_EN in the same way as the design.
module tb_jtag_instruction_register;

  localparam logic [31:0] ID_VALUE = 32'h1000_0001;
  localparam logic [31:0] ID_PAT   = 32'hA5C3_0F96;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RST_OP  = 4'b0001;
  localparam logic [2:0] RST_SEL = 3'b010;
  localparam logic       RST_DR  = 1'b1;
  localparam logic [2:0] OP1_SEL = 3'b010;
  localparam logic       OP1_DR  = 1'b0;
`else
  localparam logic [3:0] RST_OP  = 4'b1111;
  localparam logic [2:0] RST_SEL = 3'b100;
  localparam logic       RST_DR  = 1'b0;
  localparam logic [2:0] OP1_SEL = 3'b000;
  localparam logic       OP1_DR  = 1'b1;
`endif

  localparam logic [9:0] T_RST  = 10'd1 << 9;
  localparam logic [9:0] T_RLOW = 10'd1 << 8;
  localparam logic [9:0] T_CIR  = 10'd1 << 7;
  localparam logic [9:0] T_SIR  = 10'd1 << 6;
  localparam logic [9:0] T_UIR  = 10'd1 << 5;
  localparam logic [9:0] T_CDR  = 10'd1 << 4;
  localparam logic [9:0] T_SDR  = 10'd1 << 3;
  localparam logic [9:0] T_SEL  = 10'd1 << 2;
  localparam logic [9:0] T_TDI  = 10'd1 << 1;
  localparam logic [9:0] T_UTDO = 10'd1 << 0;
  localparam logic [9:0] IRSH   = T_CIR | T_SIR | T_SEL;
  localparam logic [9:0] DRSH   = T_CDR | T_SDR;

  typedef struct {
    string      name;
    logic [9:0] in;
    bit         chk_ir;
    logic [3:0] instr;
    logic [2:0] sel;
    bit         chk_tdo;
    logic       tdo;
  } vec_t;

  typedef struct {
    string name;
    logic  tdo;
  } sb_t;

  logic TCK = 1'b0;
  logic TRST;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  jtag_instruction_register_if #(.IR_WIDTH(4)) bus ();

  jtag_instruction_register #(
    .IR_WIDTH     (4),
    .IDCODE_VALUE (ID_VALUE),
    .IDCODE_OPCODE(4'b0001)
  ) dut (
    .TCK (TCK),
    .TRST(TRST),
    .jif (bus)
  );

  always #5 TCK = ~TCK;

  function automatic vec_t mk(input string name, input logic [9:0] in, input bit chk_ir,
                              input logic [3:0] instr, input logic [2:0] sel,
                              input bit chk_tdo, input logic tdo);
    vec_t v;
    v.name = name; v.in = in; v.chk_ir = chk_ir; v.instr = instr;
    v.sel = sel; v.chk_tdo = chk_tdo; v.tdo = tdo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] in);
    TRST         = in[9];
    bus.Resetn   = ~in[8];
    bus.ClockIR  = in[7];
    bus.ShiftIR  = in[6];
    bus.UpdateIR = in[5];
    bus.ClockDR  = in[4];
    bus.ShiftDR  = in[3];
    bus.Select   = in[2];
    bus.TDI      = in[1];
    bus.UserTDO  = in[0];
  endtask

  // One TCK cycle: inputs held over the rising edge, Instr/decode checked after it,
  // TDO checked after the following falling edge.
  task automatic apply(input vec_t v);
    sb_t e;
    drive(v.in);
    if (v.chk_tdo) begin
      e.name = v.name;
      e.tdo  = v.tdo;
      sb.push_back(e);
    end
    @(posedge TCK);
    #1;
    if (v.chk_ir) begin
      check({v.name, ":instr"}, 32'(bus.Instr), 32'(v.instr));
      check({v.name, ":sel"}, 32'({bus.SelBypass, bus.SelIdcode, bus.SelExtest}), 32'(v.sel));
    end
    @(negedge TCK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ":tdo"}, 32'(bus.TDO), 32'(e.tdo));
    end
  endtask

  initial begin
    logic [31:0] idv;
    logic [31:0] pat;
    logic [7:0]  utog;
    idv  = ID_VALUE;
    pat  = ID_PAT;
    utog = 8'b1011_0010;

    // reset, IR scan to BYPASS, BYPASS path, EXTEST, Resetn, user IR load
    vecs.push_back(mk("rst0",     T_RST,               1, RST_OP,  RST_SEL, 1, 1'b0));
    vecs.push_back(mk("rst1",     T_RST,               1, RST_OP,  RST_SEL, 1, 1'b0));
    vecs.push_back(mk("ircap",    T_CIR | T_SEL,       1, RST_OP,  RST_SEL, 1, 1'b1));
    vecs.push_back(mk("irsh1",    IRSH | T_TDI,        1, RST_OP,  RST_SEL, 1, 1'b0));
    vecs.push_back(mk("irsh2",    IRSH | T_TDI,        1, RST_OP,  RST_SEL, 1, 1'b0));
    vecs.push_back(mk("irsh3",    IRSH | T_TDI,        1, RST_OP,  RST_SEL, 1, 1'b0));
    vecs.push_back(mk("irsh4",    IRSH | T_TDI,        1, RST_OP,  RST_SEL, 1, 1'b1));
    vecs.push_back(mk("irupd",    T_UIR | T_SEL,       1, 4'b1111, 3'b100,  1, 1'b1));
    vecs.push_back(mk("byp_cap",  T_CDR,               1, 4'b1111, 3'b100,  1, 1'b0));
    vecs.push_back(mk("byp_sh1",  DRSH | T_TDI,        0, 4'b0,    3'b0,    1, 1'b1));
    vecs.push_back(mk("byp_sh0",  DRSH,                0, 4'b0,    3'b0,    1, 1'b0));
    vecs.push_back(mk("byp_sh1b", DRSH | T_TDI,        0, 4'b0,    3'b0,    1, 1'b1));
    vecs.push_back(mk("byp_sh1c", DRSH | T_TDI,        0, 4'b0,    3'b0,    1, 1'b1));
    vecs.push_back(mk("byp_idle", 10'd0,               1, 4'b1111, 3'b100,  1, 1'b1));
    vecs.push_back(mk("ex_cap",   T_CIR | T_SEL,       0, 4'b0,    3'b0,    1, 1'b1));
    vecs.push_back(mk("ex_sh1",   IRSH,                1, 4'b1111, 3'b100,  1, 1'b0));
    vecs.push_back(mk("ex_sh2",   IRSH,                0, 4'b0,    3'b0,    1, 1'b0));
    vecs.push_back(mk("ex_sh3",   IRSH,                0, 4'b0,    3'b0,    1, 1'b0));
    vecs.push_back(mk("ex_sh4",   IRSH,                1, 4'b1111, 3'b100,  1, 1'b0));
    vecs.push_back(mk("ex_upd",   T_UIR | T_SEL,       1, 4'b0000, 3'b001,  1, 1'b0));
    vecs.push_back(mk("ex_dr0",   DRSH,                1, 4'b0000, 3'b001,  1, 1'b0));
    vecs.push_back(mk("ex_dr1",   DRSH | T_TDI,        1, 4'b0000, 3'b001,  1, 1'b1));
    vecs.push_back(mk("rstn",     T_RLOW,              1, RST_OP,  RST_SEL, 1, RST_DR));
    vecs.push_back(mk("usr_cap",  T_CIR | T_SEL,       1, RST_OP,  RST_SEL, 1, 1'b1));
    vecs.push_back(mk("usr_sh0",  IRSH,                0, 4'b0,    3'b0,    1, 1'b0));
    vecs.push_back(mk("usr_sh1",  IRSH | T_TDI,        0, 4'b0,    3'b0,    1, 1'b0));
    vecs.push_back(mk("usr_sh2",  IRSH | T_TDI,        0, 4'b0,    3'b0,    1, 1'b0));
    vecs.push_back(mk("usr_sh3",  IRSH,                1, RST_OP,  RST_SEL, 1, 1'b0));
    vecs.push_back(mk("usr_upd",  T_UIR | T_SEL,       1, 4'b0110, 3'b000,  1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // user instruction: TDO follows UserTDO
    for (int i = 0; i < 8; i++) begin
      logic u;
      u = utog[i];
      apply(mk("usr_dr", DRSH | (u ? T_UTDO : 10'd0), 1, 4'b0110, 3'b000, 1, u));
    end

    // UpdateIR together with ClockIR/ShiftIR: update wins, shift dropped
    apply(mk("sim_cap", T_CIR | T_SEL,                 1, 4'b0110, 3'b000, 1, 1'b1));
    apply(mk("sim_sh1", IRSH | T_TDI,                  0, 4'b0,    3'b0,   1, 1'b0));
    apply(mk("sim_sh2", IRSH,                          0, 4'b0,    3'b0,   1, 1'b0));
    apply(mk("sim_sh3", IRSH | T_TDI,                  0, 4'b0,    3'b0,   1, 1'b0));
    apply(mk("sim_sh4", IRSH,                          1, 4'b0110, 3'b000, 1, 1'b1));
    apply(mk("sim_both", IRSH | T_UIR | T_TDI,         1, 4'b0101, 3'b000, 1, 1'b1));
    apply(mk("sim_upd2", T_UIR | T_SEL,                1, 4'b0101, 3'b000, 1, 1'b1));

    // TRST in the middle of an IR shift discards the partial content
    apply(mk("mid_cap", T_CIR | T_SEL,                 1, 4'b0101, 3'b000,  1, 1'b1));
    apply(mk("mid_sh1", IRSH | T_TDI,                  0, 4'b0,    3'b0,    1, 1'b0));
    apply(mk("mid_sh2", IRSH | T_TDI,                  0, 4'b0,    3'b0,    1, 1'b0));
    apply(mk("mid_trst", T_RST | IRSH | T_TDI,         1, RST_OP,  RST_SEL, 1, 1'b0));
    apply(mk("mid_upd", T_UIR | T_SEL,                 1, 4'b0001, OP1_SEL, 1, 1'b1));
    apply(mk("mid_dr",  DRSH | T_UTDO,                 1, 4'b0001, OP1_SEL, 1, OP1_DR));

`ifdef JTAG_IDCODE_EN
    // IDCODE scan out, then TDI bits emerging after passing through bit 31
    apply(mk("id_rst", T_RST,                          1, RST_OP, RST_SEL, 1, 1'b0));
    apply(mk("id_cap", T_CDR,                          1, RST_OP, RST_SEL, 1, idv[0]));
    for (int k = 1; k <= 40; k++) begin
      logic b, ex;
      b  = pat[k-1];
      ex = (k < 32) ? idv[k] : pat[k-32];
      apply(mk($sformatf("id_sh%0d", k), DRSH | (b ? T_TDI : 10'd0), 0, 4'b0, 3'b0, 1, ex));
    end
`else
    // first DR scan after reset goes through BYPASS and returns 0
    apply(mk("nid_rst", T_RST,                         1, RST_OP, RST_SEL, 1, 1'b0));
    apply(mk("nid_cap", T_CDR,                         1, RST_OP, RST_SEL, 1, 1'b0));
    apply(mk("nid_sh1", DRSH | T_TDI,                  0, 4'b0,   3'b0,    1, 1'b1));
    apply(mk("nid_sh0", DRSH,                          0, 4'b0,   3'b0,    1, 1'b0));
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
